// File: rtl/demux_tdm_1x4_pkg.sv
// Shared types and constants for the 1x4 TDM demultiplexer.
// Optional error counter is enabled with DEMUX_TDM_ERR_CNT_EN.
package demux_tdm_pkg;
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_e;

  localparam logic [1:0] SLOT_E0     = 2'd0;
  localparam logic [1:0] SLOT_E1     = 2'd1;
  localparam logic [1:0] SLOT_E2     = 2'd2;
  localparam logic [1:0] SLOT_E3     = 2'd3;
  localparam int         NUM_SLOTS   = 4;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;
endpackage

// File: rtl/demux_tdm_1x4_if.sv
// Serial-in / channels-out bundle of the TDM demultiplexer.
// ERR_CLR / ERR_CNT exist only when DEMUX_TDM_ERR_CNT_EN is defined.
interface demux_tdm_1x4_if #(parameter int WIDTH = 1);
  logic             EN;
  logic             SYNC;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] E0, E1, E2, E3;
  logic [1:0]       S;
  logic             VALID;
  logic             LOCKED;
  logic             ERR;
`ifdef DEMUX_TDM_ERR_CNT_EN
  logic             ERR_CLR;
  logic [7:0]       ERR_CNT;
`endif

  // Link side: drives the serial stream, observes the channels.
  modport master (
`ifdef DEMUX_TDM_ERR_CNT_EN
    output ERR_CLR,
    input  ERR_CNT,
`endif
    output EN, SYNC, D,
    input  E0, E1, E2, E3, S, VALID, LOCKED, ERR
  );

  // Demultiplexer side.
  modport slave (
`ifdef DEMUX_TDM_ERR_CNT_EN
    input  ERR_CLR,
    output ERR_CNT,
`endif
    input  EN, SYNC, D,
    output E0, E1, E2, E3, S, VALID, LOCKED, ERR
  );
endinterface

// File: rtl/demux_tdm_1x4_align.sv
// Frame alignment: HUNT/LOCK FSM, slot counter, lock flag and error pulse.
// Emits write strobes for the shadow registers and a frame-done strobe.
module demux_tdm_align
  import demux_tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       sync_i,
  output logic [1:0] slot_o,
  output logic       locked_o,
  output logic       err_o,
  output logic       err_set_o,
  output logic       wr_en_o,
  output logic [1:0] wr_slot_o,
  output logic       done_o
);
  state_e     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic       err_q;

  // State, slot counter and registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      s_q     <= SLOT_E0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      err_q   <= err_set_o;
    end
  end

  // Next state and per-strobe actions; nothing happens without EN.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    wr_en_o   = 1'b0;
    wr_slot_o = SLOT_E0;
    done_o    = 1'b0;
    err_set_o = 1'b0;
    if (en_i) begin
      case (state_q)
        HUNT: begin
          if (sync_i) begin
            wr_en_o = 1'b1;
            s_d     = SLOT_E1;
            state_d = LOCK;
          end
        end
        LOCK: begin
          // SYNC always restarts the frame; a missing SYNC at slot 0 is flywheeled.
          if (sync_i || s_q == SLOT_E0) begin
            wr_en_o   = 1'b1;
            s_d       = SLOT_E1;
            err_set_o = sync_i && (s_q != SLOT_E0);
          end else if (s_q == SLOT_E3) begin
            // Slot 3 bypasses the shadow and commits the whole frame.
            done_o = 1'b1;
            s_d    = SLOT_E0;
          end else begin
            wr_en_o   = 1'b1;
            wr_slot_o = s_q;
            s_d       = s_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign slot_o   = s_q;
  assign locked_o = (state_q == LOCK);
  assign err_o    = err_q;
endmodule

// File: rtl/demux_tdm_1x4.sv
// 1x4 TDM demultiplexer: shadows slots 0..2 and commits all four channels
// atomically on slot 3. Optional ERR counter under DEMUX_TDM_ERR_CNT_EN.
module demux_tdm_1x4
  import demux_tdm_pkg::*;
#(
  parameter int WIDTH = 1
)(
  input logic            CLK,
  input logic            RST_N,
  demux_tdm_1x4_if.slave bus
);
  logic                            wr_en, done, err_set;
  logic [1:0]                      wr_slot;
  logic [2:0][WIDTH-1:0]           shadow_q;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] e_q;
  logic                            valid_q;

  demux_tdm_align u_align (
    .clk       (CLK),
    .rst_n     (RST_N),
    .en_i      (bus.EN),
    .sync_i    (bus.SYNC),
    .slot_o    (bus.S),
    .locked_o  (bus.LOCKED),
    .err_o     (bus.ERR),
    .err_set_o (err_set),
    .wr_en_o   (wr_en),
    .wr_slot_o (wr_slot),
    .done_o    (done)
  );

  // Shadow capture of slots 0..2 of the frame in progress.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     shadow_q          <= '0;
    else if (wr_en) shadow_q[wr_slot] <= bus.D;
  end

  // Atomic frame commit: slot 3 comes straight from D in the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      e_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= done;
      if (done) e_q <= {bus.D, shadow_q[2], shadow_q[1], shadow_q[0]};
    end
  end

  assign bus.E0    = e_q[0];
  assign bus.E1    = e_q[1];
  assign bus.E2    = e_q[2];
  assign bus.E3    = e_q[3];
  assign bus.VALID = valid_q;

`ifdef DEMUX_TDM_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating error count; a clear that meets a new error leaves 1.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.ERR_CLR)                               err_cnt_d = {7'd0, err_set};
    else if (err_set && err_cnt_q != ERR_CNT_MAX)  err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error count register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign bus.ERR_CNT = err_cnt_q;
`endif
endmodule

// File: tb/tb_demux_tdm_1x4.sv
// Directed bench for demux_tdm_1x4 with a frame scoreboard.
// Counter checks run when DEMUX_TDM_ERR_CNT_EN is defined.
module tb_demux_tdm_1x4;
  localparam int W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  int   err_base;
  logic [4*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  demux_tdm_1x4_if #(.WIDTH(W)) bus ();

  demux_tdm_1x4 #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge; return just after the rising edge.
  task automatic step(input logic en, input logic sync, input logic [W-1:0] d);
    @(negedge clk);
    bus.EN = en; bus.SYNC = sync; bus.D = d;
    @(posedge clk);
    #1;
  endtask

  // Frame f = {E0,E1,E2,E3}; gap idle cycles before each strobe.
  task automatic send_frame(input logic [4*W-1:0] f, input bit sync_first, input int gap);
    exp_q.push_back(f);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, '0);
      step(1'b1, (i == 0) && sync_first, f[(3-i)*W +: W]);
    end
    chk("valid_on_slot3", bus.VALID, 1);
    chk("s_wrap", bus.S, 0);
  endtask

  // Scoreboard: every VALID pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ERR === 1'b1) err_seen++;
      if (bus.VALID === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_valid", bus.VALID, 0);
        else chk("frame", {bus.E0, bus.E1, bus.E2, bus.E3}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.EN = 1'b0; bus.SYNC = 1'b0; bus.D = '0;
`ifdef DEMUX_TDM_ERR_CNT_EN
    bus.ERR_CLR = 1'b0;
`endif
    // Reset state
    repeat (3) step(1'b1, 1'b1, '1);
    chk("rst_e", {bus.E0, bus.E1, bus.E2, bus.E3}, 0);
    chk("rst_s", bus.S, 0);
    chk("rst_locked", bus.LOCKED, 0);
    chk("rst_valid", bus.VALID, 0);
    chk("rst_err", bus.ERR, 0);
`ifdef DEMUX_TDM_ERR_CNT_EN
    chk("rst_errcnt", bus.ERR_CNT, 0);
`endif
    @(negedge clk); rst_n = 1'b1; bus.EN = 1'b0;

    // Hunt: strobes without SYNC are ignored
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '1);
      chk("hunt_s", bus.S, 0);
      chk("hunt_locked", bus.LOCKED, 0);
      chk("hunt_e", {bus.E0, bus.E1, bus.E2, bus.E3}, 0);
    end

    // Basic frame 0,1,0,1, back-to-back strobes
    send_frame(4'b0101, 1'b1, 0);
    chk("basic_locked", bus.LOCKED, 1);
    chk("basic_e", {bus.E0, bus.E1, bus.E2, bus.E3}, 4'b0101);

    // Back-to-back second frame with SYNC, then flywheel frame without SYNC
    send_frame(4'b1001, 1'b1, 0);
    send_frame(4'b0110, 1'b0, 0);

    // Idle cycle: outputs hold, no pulses
    step(1'b0, 1'b1, '1);
    chk("idle_valid", bus.VALID, 0);
    chk("idle_err", bus.ERR, 0);
    chk("idle_s", bus.S, 0);
    chk("idle_e", {bus.E0, bus.E1, bus.E2, bus.E3}, 4'b0110);

    // Misaligned SYNC at S=10
    err_base = err_seen;
    step(1'b1, 1'b1, '1);
    step(1'b1, 1'b0, '0);
    chk("mis_s_before", bus.S, 2);
    step(1'b1, 1'b1, '0);
    chk("mis_err", bus.ERR, 1);
    chk("mis_valid", bus.VALID, 0);
    chk("mis_s", bus.S, 1);
    chk("mis_hold_e", {bus.E0, bus.E1, bus.E2, bus.E3}, 4'b0110);
    chk("mis_locked", bus.LOCKED, 1);
    exp_q.push_back(4'b0111);
    step(1'b1, 1'b0, '1);
    chk("mis_err_one_cycle", bus.ERR, 0);
    step(1'b1, 1'b0, '1);
    step(1'b1, 1'b0, '1);
    chk("mis_valid_after", bus.VALID, 1);
    step(1'b0, 1'b0, '0);
    chk("mis_err_count", err_seen - err_base, 1);

    // Flywheel with EN every 3rd cycle, SYNC only on first frame
    err_base = err_seen;
    send_frame(4'b1010, 1'b1, 2);
    send_frame(4'b1100, 1'b0, 2);
    send_frame(4'b0011, 1'b0, 2);
    step(1'b0, 1'b0, '0);
    chk("fly_no_err", err_seen - err_base, 0);
    chk("fly_locked", bus.LOCKED, 1);

    // Asynchronous reset mid-frame with EN active
    step(1'b1, 1'b1, '1);
    chk("pre_rst_s", bus.S, 1);
    @(negedge clk); bus.EN = 1'b1; bus.SYNC = 1'b1; bus.D = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_e", {bus.E0, bus.E1, bus.E2, bus.E3}, 0);
    chk("arst_s", bus.S, 0);
    chk("arst_locked", bus.LOCKED, 0);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '1);
    @(negedge clk); rst_n = 1'b1; bus.EN = 1'b0;
    step(1'b1, 1'b0, '1);
    chk("post_rst_hunt_s", bus.S, 0);
    chk("post_rst_locked", bus.LOCKED, 0);
    send_frame(4'b1110, 1'b1, 1);

`ifdef DEMUX_TDM_ERR_CNT_EN
    // 300 misaligned SYNCs saturate the counter
    err_base = err_seen;
    for (int i = 0; i < 301; i++) step(1'b1, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    chk("cnt_err_pulses", err_seen - err_base, 300);
    chk("cnt_saturate", bus.ERR_CNT, 8'hFF);
    @(negedge clk); bus.ERR_CLR = 1'b1; bus.EN = 1'b0;
    @(posedge clk); #1;
    chk("cnt_clear", bus.ERR_CNT, 0);
    @(negedge clk); bus.ERR_CLR = 1'b1; bus.EN = 1'b1; bus.SYNC = 1'b1; bus.D = '0;
    @(posedge clk); #1;
    chk("cnt_clr_with_err", bus.ERR_CNT, 1);
    chk("cnt_clr_err_pulse", bus.ERR, 1);
    @(negedge clk); bus.ERR_CLR = 1'b0; bus.EN = 1'b0; bus.SYNC = 1'b0;
    step(1'b0, 1'b0, '0);
`endif

    step(1'b0, 1'b0, '0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
